// File: rtl/frame_sched_pkg.sv
// Shared types and default geometry for the frame write scheduler.
// The defaults describe a 512x384 RGB888 frame held in a single BRAM.
package frame_sched_pkg;

  localparam int DEF_FRAME_WORDS = 196608;
  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_DATA_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIX  = 2'd1,
    GNT_FILL = 2'd2
  } grant_src_t;

endpackage

// File: rtl/wr_fifo2.sv
// Two-entry FIFO that buffers pixel write requests ahead of the BRAM port arbiter.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module wr_fifo2 #(
  parameter int WIDTH = 42
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rdPtr;
  logic             r_wrPtr;
  logic [1:0]       r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == 2'd2);
  assign o_empty  = (r_count == 2'd0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_dout   = r_mem[r_rdPtr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_doPush) r_wrPtr <= ~r_wrPtr;
      if (w_doPop)  r_rdPtr <= ~r_rdPtr;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Shares BRAM port A between buffered pixel writes and a full-frame colour fill.
// Contended cycles alternate round-robin; all port outputs are registered.
module frame_write_scheduler
  import frame_sched_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [DATA_W-1:0] fill_color,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  fill_state_t              r_state;
  fill_state_t              w_stateNext;
  grant_src_t               w_grant;
  grant_src_t               r_lastGrant;
  logic [ADDR_W-1:0]        r_fillAddr;
  logic [DATA_W-1:0]        r_fillColor;
  logic                     r_ena;
  logic [ADDR_W-1:0]        r_addra;
  logic [DATA_W-1:0]        r_dina;
  logic                     r_overflow;

  logic                     w_fifoFull;
  logic                     w_fifoEmpty;
  logic                     w_push;
  logic                     w_pop;
  logic [ADDR_W+DATA_W-1:0] w_fifoDout;
  logic [ADDR_W-1:0]        w_pixAddr;
  logic [DATA_W-1:0]        w_pixData;
  logic                     w_pixReq;
  logic                     w_fillReq;
  logic                     w_contended;

  assign w_pixAddr   = w_fifoDout[ADDR_W+DATA_W-1 -: ADDR_W];
  assign w_pixData   = w_fifoDout[DATA_W-1:0];
  assign w_pixReq    = !w_fifoEmpty;
  // An abort suppresses the fill request in its own cycle so no extra word slips out.
  assign w_fillReq   = (r_state == ST_FILL) && !fill_abort;
  assign w_contended = w_pixReq && w_fillReq;
  assign w_pop       = (w_grant == GNT_PIX);
  assign w_push      = wr_valid && (!w_fifoFull || w_pop);

  wr_fifo2 #(
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({wr_addr, wr_data}),
    .o_dout  (w_fifoDout),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  always_comb begin
    w_grant = GNT_NONE;
    if (w_contended) begin
      w_grant = (r_lastGrant == GNT_PIX) ? GNT_FILL : GNT_PIX;
    end else if (w_pixReq) begin
      w_grant = GNT_PIX;
    end else if (w_fillReq) begin
      w_grant = GNT_FILL;
    end
  end

  // The round-robin pointer only moves when both sides actually competed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= GNT_FILL;
    end else if (w_contended) begin
      r_lastGrant <= w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE: if (fill_start) w_stateNext = ST_FILL;
      ST_FILL: begin
        if (fill_abort) begin
          w_stateNext = ST_IDLE;
        end else if (w_grant == GNT_FILL && r_fillAddr == LAST_ADDR) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_busy = (r_state == ST_FILL);
    fill_done = (r_state == ST_DONE);
  end

  // The counter parks on the last word rather than wrapping; a new start rewinds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fillAddr  <= '0;
      r_fillColor <= '0;
    end else if (r_state == ST_IDLE && fill_start) begin
      r_fillAddr  <= '0;
      r_fillColor <= fill_color;
    end else if (w_grant == GNT_FILL && r_fillAddr != LAST_ADDR) begin
      r_fillAddr  <= r_fillAddr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ena   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      unique case (w_grant)
        GNT_PIX: begin
          r_ena   <= 1'b1;
          r_addra <= w_pixAddr;
          r_dina  <= w_pixData;
        end
        GNT_FILL: begin
          r_ena   <= 1'b1;
          r_addra <= r_fillAddr;
          r_dina  <= r_fillColor;
        end
        default: r_ena <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr_valid && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  assign ena      = r_ena;
  assign wea      = r_ena;
  assign addra    = r_addra;
  assign dina     = r_dina;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Self-checking bench for frame_write_scheduler with an eight-word frame.
// A queue-based transaction model predicts every cycle; directed literals pin key scenarios.
module tb_frame_write_scheduler;

  localparam int FW = 8;
  localparam int AW = 18;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fill_start;
  logic          fill_abort;
  logic [DW-1:0] fill_color;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          fill_busy;
  logic          fill_done;
  logic          overflow;

  int nChecks = 0;
  int nErrors = 0;

  frame_write_scheduler #(
    .FRAME_WORDS (FW),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_color (fill_color),
    .ena        (ena),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic s, input logic ab, input logic [DW-1:0] c);
    wr_valid   = v;
    wr_addr    = a;
    wr_data    = d;
    fill_start = s;
    fill_abort = ab;
    fill_color = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Transaction model: pending pixel writes as a queue, the fill as "next word to write",
  // and the arbiter as a single "whose turn is it when both want the port" bit.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } pix_t;

  pix_t          mq[$];
  bit            mValid = 1'b0;
  bit            mFilling, mFinishing, mFavourPix, mOvf, mEna;
  int            mNext;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData, mColor;
  logic [DW-1:0] memDut [logic [AW-1:0]];

  always @(posedge clk) begin
    bit   usePix, useFill, wasIdle, pixWant, fillWant;
    pix_t head;
    if (rst) begin
      mq.delete();
      mValid = 1'b1; mFilling = 1'b0; mFinishing = 1'b0; mFavourPix = 1'b1;
      mOvf = 1'b0; mEna = 1'b0; mNext = 0; mAddr = '0; mData = '0; mColor = '0;
    end else if (mValid) begin
      wasIdle  = !mFilling && !mFinishing;
      pixWant  = mq.size() > 0;
      fillWant = mFilling && !fill_abort;
      usePix   = 1'b0;
      useFill  = 1'b0;
      if (pixWant && fillWant) begin
        usePix     = mFavourPix;
        useFill    = !mFavourPix;
        mFavourPix = !mFavourPix;
      end else begin
        usePix  = pixWant;
        useFill = fillWant;
      end
      mFinishing = 1'b0;
      mEna = usePix || useFill;
      if (usePix) begin
        head  = mq.pop_front();
        mAddr = head.addr;
        mData = head.data;
      end
      if (useFill) begin
        mAddr = AW'(mNext);
        mData = mColor;
        if (mNext == FW - 1) begin
          mFilling   = 1'b0;
          mFinishing = 1'b1;
        end else begin
          mNext++;
        end
      end else if (mFilling && fill_abort) begin
        mFilling = 1'b0;
      end
      if (wasIdle && fill_start) begin
        mFilling = 1'b1;
        mNext    = 0;
        mColor   = fill_color;
      end
      if (wr_valid) begin
        if (mq.size() < 2) mq.push_back(pix_t'{addr: wr_addr, data: wr_data});
        else               mOvf = 1'b1;
      end
    end
  end

  // Every cycle after the first reset edge, compare all outputs against the model.
  always @(negedge clk) begin
    if (mValid) begin
      if (ena) memDut[addra] = dina;
      checkOutput("cycle_model",
                  {17'd0, ena, wea, fill_busy, fill_done, overflow, addra, dina},
                  {17'd0, mEna, mEna, mFilling, mFinishing, mOvf, mAddr, mData});
    end
  end

  initial begin
    int nFill, nPix, nDone, nWr;

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("reset_ena",  64'(ena),       64'(0));
    checkOutput("reset_addr", 64'(addra),     64'(0));
    checkOutput("reset_data", 64'(dina),      64'(0));
    checkOutput("reset_busy", 64'(fill_busy), 64'(0));
    checkOutput("reset_done", 64'(fill_done), 64'(0));
    checkOutput("reset_ovf",  64'(overflow),  64'(0));
    rst = 1'b0;

    $display("[TB] idle pixel write latency");
    applyStimulus(1'b1, 18'h00010, 24'hFF8040, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("pix_c1_ena", 64'(ena), 64'(0));
    tick();
    checkOutput("pix_c2_ena",  64'(ena),   64'(1));
    checkOutput("pix_c2_wea",  64'(wea),   64'(1));
    checkOutput("pix_c2_addr", 64'(addra), 64'(18'h00010));
    checkOutput("pix_c2_data", 64'(dina),  64'(24'hFF8040));
    tick();
    checkOutput("pix_c3_ena",  64'(ena),   64'(0));
    checkOutput("pix_c3_hold", 64'(addra), 64'(18'h00010));

    $display("[TB] plain fill");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 24'h123456);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("fill_busy_start", 64'(fill_busy), 64'(1));
    checkOutput("fill_first_gap",  64'(ena),       64'(0));
    for (int i = 0; i < FW; i++) begin
      tick();
      checkOutput("fill_ena",  64'(ena),       64'(1));
      checkOutput("fill_addr", 64'(addra),     64'(i));
      checkOutput("fill_data", 64'(dina),      64'(24'h123456));
      checkOutput("fill_done", 64'(fill_done), 64'(i == FW - 1));
      checkOutput("fill_busy", 64'(fill_busy), 64'(i != FW - 1));
    end
    tick();
    checkOutput("fill_after_done", 64'(fill_done), 64'(0));
    checkOutput("fill_after_busy", 64'(fill_busy), 64'(0));
    checkOutput("fill_after_ena",  64'(ena),       64'(0));

    $display("[TB] pixel writes interleaved with fill");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 24'hABCDEF);
    nFill = 0; nPix = 0; nDone = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (ena && dina == 24'hABCDEF) nFill++;
      if (ena && (dina == 24'h00AA55 || dina == 24'h00BB66)) nPix++;
      if (fill_done) nDone++;
      case (j)
        3:       applyStimulus(1'b1, 18'h00001, 24'h00AA55, 1'b0, 1'b0, '0);
        4:       applyStimulus(1'b1, 18'h00006, 24'h00BB66, 1'b0, 1'b0, '0);
        default: applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
      endcase
    end
    checkOutput("mix_fill_words", 64'(nFill),    64'(8));
    checkOutput("mix_pix_words",  64'(nPix),     64'(2));
    checkOutput("mix_done_count", 64'(nDone),    64'(1));
    checkOutput("mix_overflow",   64'(overflow), 64'(0));
    checkOutput("mix_mem1_kept",  64'(memDut[18'h00001]), 64'(24'h00AA55));
    checkOutput("mix_mem6_fill",  64'(memDut[18'h00006]), 64'(24'hABCDEF));
    checkOutput("mix_mem3_fill",  64'(memDut[18'h00003]), 64'(24'hABCDEF));

    $display("[TB] write burst during fill");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 24'h0F0F0F);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, AW'(32'h100 + k), DW'(32'h0A0000 + k), 1'b0, 1'b0, '0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 20; k++) tick();
    checkOutput("burst_overflow_held", 64'(overflow),  64'(1));
    checkOutput("burst_fill_over",     64'(fill_busy), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("burst_ovf_cleared", 64'(overflow), 64'(0));

    $display("[TB] abort and restart");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 24'h333333);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_pre_addr", 64'(addra), 64'(i));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, '0);
    nWr = 0; nDone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
      if (ena) nWr++;
      if (fill_done) nDone++;
    end
    checkOutput("abort_no_writes", 64'(nWr),       64'(0));
    checkOutput("abort_no_done",   64'(nDone),     64'(0));
    checkOutput("abort_idle",      64'(fill_busy), 64'(0));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 24'h444444);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("restart_start_wins", 64'(fill_busy), 64'(1));
    tick();
    checkOutput("restart_ena",  64'(ena),   64'(1));
    checkOutput("restart_addr", 64'(addra), 64'(0));
    checkOutput("restart_data", 64'(dina),  64'(24'h444444));
    for (int i = 0; i < 12; i++) tick();

    $display("[TB] reset mid-fill with a queued pixel");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 24'h555555);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b1, 18'h00200, 24'h777777, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b1, 18'h00201, 24'h888888, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_ena",  64'(ena),       64'(0));
    checkOutput("rst_mid_addr", 64'(addra),     64'(0));
    checkOutput("rst_mid_data", 64'(dina),      64'(0));
    checkOutput("rst_mid_busy", 64'(fill_busy), 64'(0));
    checkOutput("rst_mid_done", 64'(fill_done), 64'(0));
    checkOutput("rst_mid_ovf",  64'(overflow),  64'(0));
    tick();
    rst = 1'b0;
    nWr = 0; nDone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ena) nWr++;
      if (fill_done) nDone++;
    end
    checkOutput("rst_mid_no_writes", 64'(nWr),   64'(0));
    checkOutput("rst_mid_no_done",   64'(nDone), 64'(0));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/frame_write_scheduler.md
FRAME_WRITE_SCHEDULER -- requirements
Module: frame_write_scheduler

Interface
REQ-001 Parameter FRAME_WORDS, default 196608, SHALL set the number of frame words swept by a fill (512x384 image).
REQ-002 Parameter ADDR_W, default 18, SHALL set the BRAM address width.
REQ-003 Parameter DATA_W, default 24, SHALL set the pixel width (RGB888).
REQ-004 clk  in  1  SHALL be the single clock (100 MHz domain); all logic SHALL be on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 wr_valid  in  1  SHALL flag a one-cycle pixel write request from the pixel writer.
REQ-007 wr_addr  in  ADDR_W  SHALL be the write address, qualified by wr_valid.
REQ-008 wr_data  in  DATA_W  SHALL be the write pixel, qualified by wr_valid.
REQ-009 fill_start  in  1  SHALL be a one-cycle pulse requesting a full-frame fill.
REQ-010 fill_abort  in  1  SHALL be a one-cycle pulse cancelling an active fill.
REQ-011 fill_color  in  DATA_W  SHALL be the fill pixel, sampled on the accepted fill_start.
REQ-012 ena, wea  out  1 each  SHALL drive BRAM port A enable/write-enable.
REQ-013 addra  out  ADDR_W;  dina  out  DATA_W  SHALL drive BRAM port A address/data.
REQ-014 fill_busy  out  1  SHALL be high while state is FILL.
REQ-015 fill_done  out  1  SHALL pulse one cycle when the last fill word is issued.
REQ-016 overflow  out  1  SHALL be a sticky flag set when a pixel write is dropped.

Function
REQ-017 Pixel writes SHALL enter a 2-entry FIFO; wr_valid with FIFO full and no pop that cycle SHALL drop the write and set overflow.
REQ-018 Push and pop in the same cycle SHALL both occur, with occupancy unchanged.
REQ-019 Fill FSM states SHALL be IDLE, FILL, DONE; IDLE->FILL on fill_start (counter=0, color latched); FILL->DONE when word FRAME_WORDS-1 is granted; DONE->IDLE after one cycle with fill_done=1.
REQ-020 fill_start while in FILL or DONE SHALL be ignored; fill_abort in FILL SHALL return to IDLE with no fill_done; fill_abort and fill_start in the same IDLE cycle: start SHALL win.
REQ-021 Arbitration each cycle: only one requester -> it SHALL be granted; both (FIFO non-empty and FILL) -> round-robin, granting the one not granted last; the last-grant pointer SHALL update only on contended cycles.
REQ-022 The fill address counter SHALL advance only on a fill grant, SHALL never exceed FRAME_WORDS-1, and SHALL not wrap.
REQ-023 Port outputs SHALL be registered: a grant in cycle c SHALL drive ena=wea=1 with its addr/data in cycle c+1; no grant SHALL give ena=wea=0 and hold addra/dina.
REQ-024 Uncontended pixel-write latency: wr_valid in cycle c -> port write in cycle c+2.
REQ-025 Write ordering SHALL be grant order; a pixel write to an address already filled SHALL persist, one not yet reached SHALL be overwritten by the fill.

Reset
REQ-026 rst SHALL force, on the next edge: ena=wea=0, addra=0, dina=0, fill_busy=0, fill_done=0, overflow=0, FIFO empty, state IDLE, counter 0, RR pointer to favour pixel writes; reset mid-fill SHALL abandon the fill with no fill_done.
REQ-027 rst SHALL override all concurrent inputs.

Structure
REQ-028 Package frame_sched_pkg SHALL hold the fill state enum, default ADDR_W/DATA_W/FRAME_WORDS, and the grant-source enum.
REQ-029 The FIFO SHALL be sub-module wr_fifo2 (2 entries, ADDR_W+DATA_W wide, push/pop/full/empty).

Verification (FRAME_WORDS=8 unless stated)
REQ-030 wr_valid, addr 0x00010, data 0xFF8040, idle fill -> ena=wea=1, addra=0x00010, dina=0xFF8040 exactly 2 cycles later, one cycle wide.
REQ-031 fill_start, color 0x123456 -> 8 consecutive writes addr 0..7 data 0x123456, fill_done one cycle after addr 7 write issues, fill_busy low afterwards.
REQ-032 During fill, wr_valid at fill addr 3 -> writes alternate fill/pixel, pixel write present, fill still completes 8 words, overflow=0.
REQ-033 During fill, wr_valid on 4 consecutive cycles -> at least one drop, overflow=1 and held until rst.
REQ-034 fill_abort after 3 fill writes -> no further fill writes, no fill_done; new fill_start restarts at addr 0.
REQ-035 rst asserted at fill addr 5 with FIFO holding 1 entry -> next cycle all outputs 0, no further port writes.
